// File: rtl/sender_ot_pack_n_if.sv
// Request/response bundle between the OT sender and its requester.
// master drives the request and operands, slave returns packed results and status.
interface sender_ot_pack_n_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_MSG = 2
);
    logic                       gen;
    logic [NUM_MSG*WIDTH-1:0]   message;
    logic [WIDTH-1:0]           N;
    logic [WIDTH-1:0]           d;
    logic [NUM_MSG*WIDTH-1:0]   rand_val;
    logic [WIDTH-1:0]           received_data;
    logic [NUM_MSG*WIDTH-1:0]   packed_data;
    logic                       gen_end;
    logic                       busy;
    logic                       err;

    modport master (
        output gen, message, N, d, rand_val, received_data,
        input  packed_data, gen_end, busy, err
    );

    modport slave (
        input  gen, message, N, d, rand_val, received_data,
        output packed_data, gen_end, busy, err
    );
endinterface

// File: rtl/sender_ot_pack_n.sv
// OT sender packing: per channel, packed = (message + (received - rand)^d) mod N,
// computed with bit-serial shift-add modular multiplies and fixed-latency exponentiation.
module sender_ot_pack_n #(
    parameter int WIDTH   = 32,
    parameter int NUM_MSG = 2
) (
    input  logic clk,
    input  logic rstn,
    sender_ot_pack_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int MW = $clog2(NUM_MSG);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [MW-1:0]    LAST_CH  = MW'(NUM_MSG - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [2:0] {IDLE, REDUCE, EXP, PACK, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]         n_r, d_r;
    logic [WIDTH-1:0]         msg_r [NUM_MSG];
    logic [WIDTH-1:0]         mag_r [NUM_MSG];
    logic [NUM_MSG-1:0]       neg_r;
    logic [MW-1:0]            ch;
    logic [CW-1:0]            bit_cnt, exp_idx;
    logic [WIDTH-1:0]         acc_a, acc_b, sh_a, sh_b, base_r, res_r;
    logic [NUM_MSG*WIDTH-1:0] packed_r;
    logic                     err_r;

    logic                     in_bad;
    logic signed [WIDTH:0]    diff_in [NUM_MSG];
    logic [WIDTH-1:0]         mag_in  [NUM_MSG];
    logic [NUM_MSG-1:0]       neg_in;
    logic [WIDTH-1:0]         step_a, step_b, res_upd, pack_term, pack_val;
    logic                     gen_end_c, busy_c;

    function automatic logic [WIDTH+1:0] cond_sub(input logic [WIDTH+1:0] v,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] nx;
        nx = {2'b00, n};
        return (v >= nx) ? v - nx : v;
    endfunction

    // One interleaved step: 2*acc + bit*addend, folded back below n (< 3n before folding).
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                  input logic             bit_in,
                                                  input logic [WIDTH-1:0] addend,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] t;
        t = {1'b0, acc, 1'b0};
        if (bit_in) t = t + {2'b00, addend};
        t = cond_sub(cond_sub(t, n), n);
        return WIDTH'(t);
    endfunction

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] t;
        t = {2'b00, a} + {2'b00, b};
        t = cond_sub(t, n);
        return WIDTH'(t);
    endfunction

    always_comb begin
        in_bad = (bus.N < WIDTH'(2));
        for (int i = 0; i < NUM_MSG; i++) begin
            if (bus.message[i*WIDTH +: WIDTH] >= bus.N) in_bad = 1'b1;
            diff_in[i] = $signed({1'b0, bus.received_data})
                       - $signed({1'b0, bus.rand_val[i*WIDTH +: WIDTH]});
            neg_in[i]  = diff_in[i][WIDTH];
            mag_in[i]  = neg_in[i] ? WIDTH'(-diff_in[i]) : WIDTH'(diff_in[i]);
        end
    end

    // REDUCE multiplies magnitude by 1; EXP runs result*base and base*base side by side.
    always_comb begin
        step_a    = mod_step(acc_a, sh_a[WIDTH-1], (state == REDUCE) ? ONE : base_r, n_r);
        step_b    = mod_step(acc_b, sh_b[WIDTH-1], base_r, n_r);
        res_upd   = d_r[exp_idx] ? step_a : res_r;
        pack_term = (neg_r[ch] && d_r[0]) ? n_r - res_r : res_r;
        pack_val  = add_mod(msg_r[ch], pack_term, n_r);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.gen) state_nxt = in_bad ? DONE : REDUCE;
            REDUCE:  if (bit_cnt == LAST_BIT) state_nxt = EXP;
            EXP:     if (bit_cnt == LAST_BIT && exp_idx == LAST_BIT) state_nxt = PACK;
            PACK:    state_nxt = (ch == LAST_CH) ? DONE : REDUCE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gen_end_c = (state == DONE);
        busy_c    = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_r      <= '0;
            d_r      <= '0;
            neg_r    <= '0;
            ch       <= '0;
            bit_cnt  <= '0;
            exp_idx  <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            base_r   <= '0;
            res_r    <= '0;
            packed_r <= '0;
            err_r    <= 1'b0;
            for (int i = 0; i < NUM_MSG; i++) begin
                msg_r[i] <= '0;
                mag_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (bus.gen) begin
                    n_r     <= bus.N;
                    d_r     <= bus.d;
                    neg_r   <= neg_in;
                    for (int i = 0; i < NUM_MSG; i++) begin
                        msg_r[i] <= bus.message[i*WIDTH +: WIDTH];
                        mag_r[i] <= mag_in[i];
                    end
                    ch      <= '0;
                    bit_cnt <= '0;
                    exp_idx <= '0;
                    acc_a   <= '0;
                    acc_b   <= '0;
                    sh_a    <= mag_in[0];
                    sh_b    <= '0;
                    base_r  <= '0;
                    res_r   <= ONE;
                    err_r   <= in_bad;
                    if (in_bad) packed_r <= '0;
                end
                REDUCE: begin
                    acc_a   <= step_a;
                    sh_a    <= sh_a << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        base_r  <= step_a;
                        res_r   <= ONE;
                        acc_a   <= '0;
                        acc_b   <= '0;
                        sh_a    <= ONE;
                        sh_b    <= step_a;
                        bit_cnt <= '0;
                        exp_idx <= '0;
                    end
                end
                EXP: begin
                    acc_a   <= step_a;
                    acc_b   <= step_b;
                    sh_a    <= sh_a << 1;
                    sh_b    <= sh_b << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        res_r   <= res_upd;
                        base_r  <= step_b;
                        acc_a   <= '0;
                        acc_b   <= '0;
                        sh_a    <= res_upd;
                        sh_b    <= step_b;
                        bit_cnt <= '0;
                        exp_idx <= exp_idx + 1'b1;
                    end
                end
                PACK: begin
                    packed_r[ch*WIDTH +: WIDTH] <= pack_val;
                    if (ch != LAST_CH) begin
                        ch      <= ch + 1'b1;
                        sh_a    <= mag_r[ch + 1'b1];
                        acc_a   <= '0;
                        bit_cnt <= '0;
                        res_r   <= ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.packed_data = packed_r;
    assign bus.err         = err_r;
    assign bus.gen_end     = gen_end_c;
    assign bus.busy        = busy_c;
endmodule

// File: tb/tb_sender_ot_pack_n.sv
// Directed bench for sender_ot_pack_n: a 32-bit/2-channel and a 16-bit/4-channel instance
// checked against hand-computed packed values, latencies and status behaviour.
module tb_sender_ot_pack_n;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sender_ot_pack_n_if #(.WIDTH(32), .NUM_MSG(2)) bus_a ();
    sender_ot_pack_n_if #(.WIDTH(16), .NUM_MSG(4)) bus_b ();

    sender_ot_pack_n #(.WIDTH(32), .NUM_MSG(2)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    sender_ot_pack_n #(.WIDTH(16), .NUM_MSG(4)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [31:0] n, input logic [31:0] dd, input logic [31:0] rcv,
                           input logic [63:0] rv, input logic [63:0] msg, input logic hold);
        @(negedge clk);
        bus_a.N = n;
        bus_a.d = dd;
        bus_a.received_data = rcv;
        bus_a.rand_val = rv;
        bus_a.message = msg;
        bus_a.gen = 1'b1;
        @(posedge clk);
        #1;
        bus_a.gen = hold;
    endtask

    task automatic op_a(input string tag, input logic [31:0] n, input logic [31:0] dd,
                        input logic [31:0] rcv, input logic [63:0] rv, input logic [63:0] msg,
                        input logic [63:0] exp_pk, input logic exp_err, input int exp_lat);
        int lat = 0;
        int bl  = 0;
        start_a(n, dd, rcv, rv, msg, 1'b0);
        // operands change right after acceptance and must not matter
        bus_a.message = '1;
        bus_a.N = 32'd7;
        bus_a.d = 32'd0;
        bus_a.rand_val = '0;
        bus_a.received_data = 32'hdead;
        do begin
            @(negedge clk);
            lat++;
            if (!bus_a.busy) bl++;
        end while (!bus_a.gen_end && lat < 5000);
        check({tag, "_end"}, 64'(bus_a.gen_end), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_pk"},  bus_a.packed_data, exp_pk);
        check({tag, "_err"}, 64'(bus_a.err), 64'(exp_err));
        check({tag, "_busy"}, 64'(bl), 64'd0);
    endtask

    task automatic op_b(input string tag, input logic [15:0] n, input logic [15:0] dd,
                        input logic [15:0] rcv, input logic [63:0] rv, input logic [63:0] msg,
                        input logic [63:0] exp_pk, input int exp_lat);
        int lat = 0;
        int bl  = 0;
        @(negedge clk);
        bus_b.N = n;
        bus_b.d = dd;
        bus_b.received_data = rcv;
        bus_b.rand_val = rv;
        bus_b.message = msg;
        bus_b.gen = 1'b1;
        @(posedge clk);
        #1;
        bus_b.gen = 1'b0;
        bus_b.rand_val = '1;
        bus_b.received_data = 16'h1234;
        do begin
            @(negedge clk);
            lat++;
            if (!bus_b.busy) bl++;
        end while (!bus_b.gen_end && lat < 3000);
        check({tag, "_end"}, 64'(bus_b.gen_end), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_pk"},  bus_b.packed_data, exp_pk);
        check({tag, "_err"}, 64'(bus_b.err), 64'd0);
        check({tag, "_busy"}, 64'(bl), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ge = 0;
        int bl = 0;
        int first = 0;
        int second = 0;
        bus_a.gen = 1'b0; bus_a.message = '0; bus_a.N = '0; bus_a.d = '0;
        bus_a.rand_val = '0; bus_a.received_data = '0;
        bus_b.gen = 1'b0; bus_b.message = '0; bus_b.N = '0; bus_b.d = '0;
        bus_b.rand_val = '0; bus_b.received_data = '0;

        repeat (3) @(negedge clk);
        check("rst_pk",   bus_a.packed_data, 64'd0);
        check("rst_end",  64'(bus_a.gen_end), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_err",  64'(bus_a.err), 64'd0);
        check("rst_pk_b", bus_b.packed_data, 64'd0);
        rstn = 1'b1;

        op_a("v029", 32'd33, 32'd3, 32'd10, {32'd12, 32'd8}, {32'd20, 32'd5},
             {32'd12, 32'd13}, 1'b0, 2115);
        op_a("v030", 32'd33, 32'd2, 32'd10, {32'd12, 32'd8}, {32'd20, 32'd5},
             {32'd24, 32'd9}, 1'b0, 2115);

        start_a(32'd33, 32'd3, 32'd10, {32'd12, 32'd8}, {32'd20, 32'd5}, 1'b0);
        repeat (500) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_pk",   bus_a.packed_data, 64'd0);
        check("mid_rst_busy", 64'(bus_a.busy), 64'd0);
        check("mid_rst_end",  64'(bus_a.gen_end), 64'd0);
        check("mid_rst_err",  64'(bus_a.err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        op_a("v_dhi", 32'd33, 32'h8000_0001, 32'd10, {32'd12, 32'd8}, {32'd20, 32'd5},
             {32'd3, 32'd22}, 1'b0, 2115);
        op_a("v_bign", 32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFF0, {32'd0, 32'hFFFF_FFFF},
             {32'hFFFF_FFFA, 32'd0}, {32'hFFFF_FFEF, 32'hFFFF_FFEC}, 1'b0, 2115);
        op_a("inv_msg", 32'd33, 32'd3, 32'd10, {32'd12, 32'd8}, {32'd33, 32'd5},
             64'd0, 1'b1, 1);
        repeat (3) @(negedge clk);
        check("err_hold", 64'(bus_a.err), 64'd1);
        check("end_once", 64'(bus_a.gen_end), 64'd0);
        op_a("inv_n1", 32'd1, 32'd3, 32'd10, {32'd12, 32'd8}, {32'd0, 32'd0},
             64'd0, 1'b1, 1);

        start_a(32'd33, 32'd0, 32'd10, {32'd12, 32'd8}, {32'd20, 32'd5}, 1'b1);
        for (int i = 1; i <= 4231; i++) begin
            @(negedge clk);
            if (!bus_a.busy) bl++;
            if (bus_a.gen_end) begin
                ge++;
                if (ge == 1) first = i;
                else second = i;
                check("hold_pk", bus_a.packed_data, {32'd21, 32'd6});
            end
        end
        bus_a.gen = 1'b0;
        check("hold_cnt",    64'(ge), 64'd2);
        check("hold_first",  64'(first), 64'd2115);
        check("hold_second", 64'(second), 64'd4231);
        check("hold_idle",   64'(bl), 64'd1);
        check("hold_err",    64'(bus_a.err), 64'd0);
        repeat (2) @(negedge clk);
        check("hold_stop",   64'(bus_a.busy), 64'd0);

        op_b("b_v1", 16'd97, 16'd5, 16'd50, {16'd60, 16'd50, 16'd7, 16'd45},
             {16'd96, 16'd0, 16'd33, 16'd12}, {16'd6, 16'd0, 16'd29, 16'd33}, 1093);
        op_b("b_v2", 16'd13, 16'd2, 16'd1000, {16'd0, 16'd1000, 16'd2000, 16'd999},
             {16'd12, 16'd0, 16'd5, 16'd7}, {16'd0, 16'd0, 16'd6, 16'd8}, 1093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sender_ot_pack_n.md
SENDER_OT_PACK_N -- requirements
Module: sender_ot_pack_n

Interface
REQ-001 Parameter WIDTH, default 32: operand width of message, modulus, exponent, random and packed values; legal range 8..64.
REQ-002 Parameter NUM_MSG, default 2: number of message channels packed per request; legal range 2..8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 gen  input  1  start request, sampled high in IDLE.
REQ-006 message  input  NUM_MSG*WIDTH  channel i message at bits [i*WIDTH +: WIDTH].
REQ-007 N  input  WIDTH  modulus.
REQ-008 d  input  WIDTH  private exponent.
REQ-009 rand_val  input  NUM_MSG*WIDTH  channel i random value, packed as for message.
REQ-010 received_data  input  WIDTH  value returned by the receiver.
REQ-011 packed_data  output  NUM_MSG*WIDTH  channel i packed result, packed as for message.
REQ-012 gen_end  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high from the cycle after gen is accepted until the gen_end cycle, inclusive.
REQ-014 err  output  1  invalid-input flag, valid while gen_end is high, held until the next accepted gen.

Function
REQ-015 Definition: packed_i = (message_i + (received_data - rand_val_i)^d) mod N, with signed difference; magnitude b_i = |received_data - rand_val_i|, r_i = b_i^d mod N, negative term (N - r_i) mod N used only when received_data < rand_val_i and d[0]=1.
REQ-016 All inputs are captured on the accepting gen cycle; later input changes have no effect on the running operation.
REQ-017 States: IDLE, REDUCE, EXP, PACK, DONE; gen while busy is ignored.
REQ-018 IDLE: on gen=1, validate inputs; if N<2 or any message_i >= N, go to DONE with err=1, packed_data all zero.
REQ-019 REDUCE: b_i mod N via interleaved shift-add modular multiply (b_i x 1), exactly WIDTH cycles, MSB first.
REQ-020 Modular multiply step: acc <= 2*acc + a_bit*b, then at most two conditional subtractions of N; acc and b stay < N; intermediates carry WIDTH+2 bits, no overflow.
REQ-021 EXP: right-to-left binary, all WIDTH exponent bits scanned (no early exit), each bit step is one parallel pair of multiplies (result*base when bit set, base*base) of WIDTH cycles; EXP lasts WIDTH*WIDTH cycles; result initialised to 1.
REQ-022 PACK: one cycle; sum = message_i + r_i or message_i + (N - r_i) per REQ-015, one conditional subtraction of N, written to channel i slice; then REDUCE for channel i+1, or DONE after channel NUM_MSG-1.
REQ-023 Latency: valid request gives gen_end exactly NUM_MSG*(WIDTH*(WIDTH+1)+1)+1 cycles after the accepting gen edge; invalid request gives gen_end 1 cycle after.
REQ-024 DONE: gen_end=1 for one cycle, then IDLE; gen seen in DONE is ignored.
REQ-025 packed_data slices update only in PACK; untouched slices keep prior values until written.
REQ-026 d=0 gives r_i=1; received_data = rand_val_i gives b_i=0, r_i=0 for d>0.

Reset
REQ-027 rstn low, at any time including mid-operation, immediately forces IDLE and packed_data=0, gen_end=0, busy=0, err=0, clearing all internal accumulators.
REQ-028 The first gen is accepted no earlier than the first rising edge with rstn high.

Verification (WIDTH=32, NUM_MSG=2 unless stated)
REQ-029 N=33, d=3, received_data=10, rand_val={12,8}, message={20,5} -> packed_data ch0=13, ch1=12, err=0, gen_end at cycle 2115.
REQ-030 Same values with d=2 -> ch0=9, ch1=24 (even exponent ignores sign).
REQ-031 N=1 or message ch1=33 with N=33 -> gen_end next cycle, err=1, packed_data=0.
REQ-032 rstn pulsed low at cycle 500 of an operation -> outputs zero at once; new gen after release completes with correct values.
REQ-033 gen held high through a whole operation -> exactly one gen_end per accepted request, busy low only in IDLE.
REQ-034 NUM_MSG=4, WIDTH=16, random N, d, inputs -> all slices match the software model of REQ-015; gen_end at cycle 4*(16*17+1)+1=1093.
